// File: rtl/optical_flow_pkg.sv
// Shared types and widths for the optical-flow run controller.
`timescale 1ns/1ps
package optical_flow_pkg;

  localparam int FLOW_CNT_WIDTH  = 17;
  localparam int FRAME_CNT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    STREAM,
    DRAIN,
    DONE,
    ERROR
  } state_t;

  // Flow counter sticks at all-ones rather than wrapping back to a plausible value.
  function automatic logic [FLOW_CNT_WIDTH-1:0] flow_sat_inc(input logic [FLOW_CNT_WIDTH-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + FLOW_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/optical_flow_ctrl.sv
// Sequences multi-frame optical-flow runs: launch, count flows, drain, check; watchdog under OPTICAL_FLOW_CTRL_WATCHDOG_EN.
// cmd_start -> busy/dp_start one cycle later; no backpressure, datapath pulses are sampled every cycle.
`timescale 1ns/1ps
module optical_flow_ctrl
  import optical_flow_pkg::*;
#(
  parameter int EXPECTED_FLOWS = 76800,
  parameter int DRAIN_CYCLES   = 64,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_start,
  input  logic                       cmd_abort,
  input  logic [FRAME_CNT_WIDTH-1:0] cmd_frames,
  output logic                       dp_start,
  input  logic                       dp_frame_done,
  input  logic                       dp_flow_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic                       timeout,
  output logic [FRAME_CNT_WIDTH-1:0] frames_done,
  output logic [FLOW_CNT_WIDTH-1:0]  flow_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0]        DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [FLOW_CNT_WIDTH-1:0] EXP_FLOWS  = FLOW_CNT_WIDTH'(EXPECTED_FLOWS);

  state_t                     state;
  logic [FRAME_CNT_WIDTH-1:0] frames_tgt;
  logic [FRAME_CNT_WIDTH-1:0] frames_nxt;
  logic [DRAIN_W-1:0]         drain_cnt;
  logic [FLOW_CNT_WIDTH-1:0]  flow_inc;
  logic                       in_frame;
  logic                       wd_hit;

  assign busy       = (state != IDLE);
  assign in_frame   = (state == STREAM) || (state == DRAIN);
  assign frames_nxt = frames_done + FRAME_CNT_WIDTH'(1);

  // Flows in the final drain cycle still count toward the frame total.
  always_comb begin
    flow_inc = flow_count;
    if (in_frame && dp_flow_valid) flow_inc = flow_sat_inc(flow_count);
  end

`ifdef OPTICAL_FLOW_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  assign wd_hit  = in_frame && (wd_cnt == WD_LAST);
  assign timeout = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == LAUNCH)              wd_cnt <= '0;
      else if (in_frame && !cmd_abort)  wd_cnt <= wd_cnt + WD_W'(1);
      if (state == IDLE && cmd_start)   timeout_q <= 1'b0;
      else if (wd_hit && !cmd_abort)    timeout_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      frames_tgt  <= '0;
      frames_done <= '0;
      drain_cnt   <= '0;
      flow_count  <= '0;
      dp_start    <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      dp_start <= 1'b0;
      done     <= 1'b0;
      if (state != IDLE && cmd_abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_start) begin
              state       <= LAUNCH;
              dp_start    <= 1'b1;
              frames_tgt  <= (cmd_frames == '0) ? FRAME_CNT_WIDTH'(1) : cmd_frames;
              frames_done <= '0;
              error       <= 1'b0;
            end
          end
          LAUNCH: begin
            flow_count <= '0;
            state      <= STREAM;
          end
          STREAM: begin
            flow_count <= flow_inc;
            if (wd_hit) begin
              state <= ERROR;
              error <= 1'b1;
            end else if (dp_frame_done) begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end
          DRAIN: begin
            flow_count <= flow_inc;
            if (wd_hit) begin
              state <= ERROR;
              error <= 1'b1;
            end else if (drain_cnt != '0) begin
              drain_cnt <= drain_cnt - DRAIN_W'(1);
            end else if (flow_inc != EXP_FLOWS) begin
              state <= ERROR;
              error <= 1'b1;
            end else begin
              frames_done <= frames_nxt;
              if (frames_nxt == frames_tgt) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state    <= LAUNCH;
                dp_start <= 1'b1;
              end
            end
          end
          DONE:    state <= IDLE;
          ERROR:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_optical_flow_ctrl.sv
// Self-checking bench for optical_flow_ctrl: directed vector table, run-level random model, reset/watchdog sequences.
`timescale 1ns/1ps
module tb_optical_flow_ctrl;

  localparam int EXP = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic        cmd_abort = 1'b0;
  logic [7:0]  cmd_frames = 8'd0;
  logic        dp_frame_done = 1'b0;
  logic        dp_flow_valid = 1'b0;
  logic        dp_start, busy, done, error, timeout;
  logic [7:0]  frames_done;
  logic [16:0] flow_count;

  int n_vec = 0;
  int n_bad = 0;
  int n_starts = 0;
  int n_done = 0;
  int plan_flows[8];
  bit plan_extra[8];

  typedef struct {
    int frames;
    int flows;
    int bad_frame;
    int bad_flows;
    int abort_flows;
    bit mid_start;
    bit start_abort;
    int e_fd;
    int e_err;
    int e_done;
    int e_fc;
    int e_starts;
  } vec_t;

  vec_t tbl[8];

  optical_flow_ctrl #(
    .EXPECTED_FLOWS(16),
    .DRAIN_CYCLES(4),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_start(cmd_start),
    .cmd_abort(cmd_abort),
    .cmd_frames(cmd_frames),
    .dp_start(dp_start),
    .dp_frame_done(dp_frame_done),
    .dp_flow_valid(dp_flow_valid),
    .busy(busy),
    .done(done),
    .error(error),
    .timeout(timeout),
    .frames_done(frames_done),
    .flow_count(flow_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dp_start) n_starts++;
    if (done) n_done++;
  end

  initial begin
    #900000;
    $display("FAIL global_time_limit: simulation still running, required to finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_start(input string name);
    for (int i = 0; i < 200 && !dp_start; i++) tick();
    if (!dp_start) check(name, 0, 1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300 && busy; i++) tick();
    if (busy) check(name, 1, 0);
  endtask

  task automatic drive_flows(input int n, input bit fd_with_last, input bit send_fd);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      dp_flow_valid = 1'b1;
      if (send_fd && fd_with_last && k == n - 1) dp_frame_done = 1'b1;
      tick();
      dp_flow_valid = 1'b0;
      dp_frame_done = 1'b0;
    end
    if (send_fd && (!fd_with_last || n == 0)) begin
      dp_frame_done = 1'b1;
      tick();
      dp_frame_done = 1'b0;
    end
  endtask

  task automatic do_run(input string tag, input int frames, input int abort_flows,
                        input bit mid_start, input bit start_abort, input bit launch_noise);
    int eff;
    eff = (frames == 0) ? 1 : frames;
    n_starts = 0;
    n_done = 0;
    cmd_frames = frames[7:0];
    cmd_start = 1'b1;
    cmd_abort = start_abort;
    tick();
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
    check({tag, " busy_at_N+1"}, busy, 1);
    check({tag, " dp_start_at_N+1"}, dp_start, 1);
    for (int f = 0; f < eff; f++) begin
      wait_start({tag, " wait_dp_start"});
      if (launch_noise) begin
        dp_flow_valid = 1'b1;
        dp_frame_done = 1'b1;
      end
      tick();
      dp_flow_valid = 1'b0;
      dp_frame_done = 1'b0;
      if (f == 0) check({tag, " dp_start_one_cycle"}, dp_start, 0);
      if (mid_start && f == 0) begin
        cmd_start = 1'b1;
        cmd_frames = 8'd5;
        tick();
        cmd_start = 1'b0;
      end
      if (abort_flows >= 0) begin
        drive_flows(abort_flows, 1'b0, 1'b0);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        check({tag, " abort_idle_next"}, busy, 0);
        break;
      end
      drive_flows(plan_flows[f], 1'($urandom_range(0, 1)), 1'b1);
      if (plan_extra[f]) begin
        dp_flow_valid = 1'b1;
        tick();
        dp_flow_valid = 1'b0;
      end
      if (plan_flows[f] + int'(plan_extra[f]) != EXP) break;
    end
    wait_idle({tag, " wait_idle"});
    tick();
    tick();
  endtask

  // Run-level reference: each frame either matches the expected total or ends the run with an error.
  function automatic void model_run(input int frames, output int fd, output int err,
                                    output int dn, output int fc, output int st);
    int eff;
    eff = (frames == 0) ? 1 : frames;
    fd = 0; err = 0; fc = 0; st = 0;
    for (int f = 0; f < eff; f++) begin
      st++;
      fc = plan_flows[f] + int'(plan_extra[f]);
      if (fc != EXP) begin
        err = 1;
        break;
      end
      fd++;
    end
    dn = (err != 0) ? 0 : 1;
  endfunction

  task automatic check_run(input string tag, input int fd, input int err, input int dn,
                           input int fc, input int st);
    check({tag, " frames_done"}, frames_done, fd);
    check({tag, " error"}, error, err);
    check({tag, " done_pulses"}, n_done, dn);
    check({tag, " flow_count"}, flow_count, fc);
    check({tag, " dp_start_pulses"}, n_starts, st);
    check({tag, " busy"}, busy, 0);
  endtask

  initial begin
    int fd, err, dn, fc, st, base, r;

    tbl[0] = '{2, 16, -1,  0, -1, 1'b0, 1'b0, 2, 0, 1, 16, 2};
    tbl[1] = '{1, 16,  0, 15, -1, 1'b0, 1'b0, 0, 1, 0, 15, 1};
    tbl[2] = '{1, 16, -1,  0,  5, 1'b0, 1'b0, 0, 0, 0,  5, 1};
    tbl[3] = '{3, 16,  2, 17, -1, 1'b0, 1'b0, 2, 1, 0, 17, 3};
    tbl[4] = '{0, 16, -1,  0, -1, 1'b1, 1'b0, 1, 0, 1, 16, 1};
    tbl[5] = '{1, 16, -1,  0, -1, 1'b0, 1'b1, 1, 0, 1, 16, 1};
    tbl[6] = '{3, 16,  1,  0, -1, 1'b0, 1'b0, 1, 1, 0,  0, 2};
    tbl[7] = '{3, 16, -1,  0, -1, 1'b0, 1'b0, 3, 0, 1, 16, 3};

    repeat (3) tick();
    check("reset busy", busy, 0);
    check("reset dp_start", dp_start, 0);
    check("reset done", done, 0);
    check("reset error", error, 0);
    check("reset timeout", timeout, 0);
    check("reset frames_done", frames_done, 0);
    check("reset flow_count", flow_count, 0);
    rst = 1'b0;
    tick();

    dp_flow_valid = 1'b1;
    dp_frame_done = 1'b1;
    repeat (3) tick();
    dp_flow_valid = 1'b0;
    dp_frame_done = 1'b0;
    check("idle_noise busy", busy, 0);
    check("idle_noise flow_count", flow_count, 0);
    check("idle_noise frames_done", frames_done, 0);

    for (int i = 0; i < 8; i++) begin
      for (int f = 0; f < 8; f++) begin
        plan_flows[f] = (f == tbl[i].bad_frame) ? tbl[i].bad_flows : tbl[i].flows;
        plan_extra[f] = 1'b0;
      end
      do_run($sformatf("vec%0d", i), tbl[i].frames, tbl[i].abort_flows,
             tbl[i].mid_start, tbl[i].start_abort, 1'(i % 2));
      check_run($sformatf("vec%0d", i), tbl[i].e_fd, tbl[i].e_err, tbl[i].e_done,
                tbl[i].e_fc, tbl[i].e_starts);
    end

    for (int n = 0; n < 20; n++) begin
      for (int f = 0; f < 8; f++) begin
        r = $urandom_range(0, 9);
        base = (r < 8) ? 16 : ((r == 8) ? 15 : 17);
        plan_extra[f] = ($urandom_range(0, 3) == 0);
        plan_flows[f] = base - int'(plan_extra[f]);
      end
      r = $urandom_range(0, 3);
      do_run($sformatf("rnd%0d", n), r, -1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      model_run(r, fd, err, dn, fc, st);
      check_run($sformatf("rnd%0d", n), fd, err, dn, fc, st);
    end

    cmd_frames = 8'd1;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    tick();
    drive_flows(16, 1'b1, 1'b1);
    tick();
    check("pre_reset flow_count", flow_count, 16);
    check("pre_reset busy", busy, 1);
    rst = 1'b1;
    #1;
    check("drain_reset busy", busy, 0);
    check("drain_reset dp_start", dp_start, 0);
    check("drain_reset done", done, 0);
    check("drain_reset error", error, 0);
    check("drain_reset timeout", timeout, 0);
    check("drain_reset frames_done", frames_done, 0);
    check("drain_reset flow_count", flow_count, 0);
    tick();
    rst = 1'b0;
    tick();
    for (int f = 0; f < 8; f++) begin
      plan_flows[f] = 16;
      plan_extra[f] = 1'b0;
    end
    do_run("post_reset", 1, -1, 1'b0, 1'b0, 1'b0);
    check_run("post_reset", 1, 0, 1, 16, 1);

    cmd_frames = 8'd1;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    tick();
    repeat (94) tick();
    check("wd_early busy", busy, 1);
    check("wd_early timeout", timeout, 0);
    repeat (14) tick();
`ifdef OPTICAL_FLOW_CTRL_WATCHDOG_EN
    check("wd timeout", timeout, 1);
    check("wd error", error, 1);
    check("wd busy", busy, 0);
    check("wd frames_done", frames_done, 0);
`else
    check("no_wd busy", busy, 1);
    check("no_wd timeout", timeout, 0);
    check("no_wd error", error, 0);
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    check("no_wd abort busy", busy, 0);
`endif
    do_run("after_wd", 1, -1, 1'b0, 1'b0, 1'b0);
    check_run("after_wd", 1, 0, 1, 16, 1);
    check("after_wd timeout", timeout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
